// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall/bubble/flush handling and load-use info.
// Optional perf counters (stall/bubble/flush) are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned STAGE_IDX = 2,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RADDR_W   = 5,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         stall_i,
  input  logic               flush_jump_i,
  input  logic               valid_i,
  input  logic [31:0]        inst_i,
  input  logic [ADDR_W-1:0]  inst_addr_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic               reg_we_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  output logic               valid_o,
  output logic [31:0]        inst_o,
  output logic [ADDR_W-1:0]  inst_addr_o,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               inst_is_load_o,
  output logic [RADDR_W-1:0] rd_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

  localparam logic [2:0] S_UP   = 3'(STAGE_IDX);
  localparam logic [2:0] S_DN   = 3'(STAGE_IDX + 1);
  localparam logic [6:0] OPC_LD = 7'b000_0011;

  logic w_hold;
  logic w_bubble;
  logic w_flush;
  logic w_squash;
  logic w_is_load;
  logic w_unused;

  // Downstream stalled means hold, even in the illegal upstream-running case.
  assign w_hold    = stall_i[S_DN];
  assign w_bubble  = stall_i[S_UP] & ~stall_i[S_DN];
  assign w_flush   = flush_jump_i & ~stall_i[S_UP] & ~stall_i[S_DN];
  assign w_squash  = w_bubble | w_flush | ~valid_i;
  assign w_is_load = (inst_i[6:0] == OPC_LD);
  assign w_unused  = ^{stall_i, 1'(CNT_W)};

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o        <= 1'b0;
      inst_o         <= NOP_INST;
      inst_addr_o    <= '0;
      op1_o          <= '0;
      op2_o          <= '0;
      reg_we_o       <= 1'b0;
      reg_waddr_o    <= '0;
      inst_is_load_o <= 1'b0;
      rd_o           <= '0;
    end else if (w_hold) begin
      valid_o        <= valid_o;
    end else if (w_squash) begin
      valid_o        <= 1'b0;
      inst_o         <= NOP_INST;
      inst_addr_o    <= '0;
      op1_o          <= '0;
      op2_o          <= '0;
      reg_we_o       <= 1'b0;
      reg_waddr_o    <= '0;
      inst_is_load_o <= 1'b0;
      rd_o           <= '0;
    end else begin
      valid_o        <= 1'b1;
      inst_o         <= inst_i;
      inst_addr_o    <= inst_addr_i;
      op1_o          <= op1_i;
      op2_o          <= op2_i;
      reg_we_o       <= reg_we_i;
      reg_waddr_o    <= reg_waddr_i;
      inst_is_load_o <= w_is_load;
      rd_o           <= RADDR_W'(inst_i[11:7]);
    end

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters; only squashes of a real instruction count as flushes.
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_hold && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_bubble && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (w_flush && valid_i && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
`endif
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver queues hand-computed expectations, monitor checks them.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        we;
    logic [4:0]  wa;
    logic        ld;
    logic [4:0]  rd;
  } out_t;

  typedef struct {
    string       tag;
    out_t        o;
    logic        chk;
    logic [3:0]  sc;
    logic [3:0]  bc;
    logic [3:0]  fc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_jump_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic        reg_we_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        inst_is_load_o;
  logic [4:0]  rd_o;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0]  stall_cnt_o;
  logic [3:0]  bubble_cnt_o;
  logic [3:0]  flush_cnt_o;
`endif

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(
    .STAGE_IDX(2), .XLEN(32), .ADDR_W(32), .RADDR_W(5),
    .NOP_INST(32'h0000_0013), .CNT_W(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_jump_i(flush_jump_i),
    .valid_i(valid_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .valid_o(valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .inst_is_load_o(inst_is_load_o), .rd_o(rd_o)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  function automatic out_t mk(input logic v, input logic [31:0] in, input logic [31:0] ad,
                              input logic [31:0] a, input logic [31:0] b, input logic w,
                              input logic [4:0] wa, input logic ld, input logic [4:0] rd);
    out_t o;
    o.valid = v; o.inst = in; o.addr = ad; o.op1 = a; o.op2 = b;
    o.we = w; o.wa = wa; o.ld = ld; o.rd = rd;
    return o;
  endfunction

  out_t R;

  task automatic drive(input string tag, input logic r, input logic [5:0] st, input logic fl,
                       input logic v, input logic [31:0] in, input logic [31:0] ad,
                       input logic [31:0] a, input logic [31:0] b, input logic w,
                       input logic [4:0] wa, input out_t e, input logic chk,
                       input logic [3:0] sc, input logic [3:0] bc, input logic [3:0] fc);
    exp_t x;
    @(negedge clk_i);
    rst_i = r; stall_i = st; flush_jump_i = fl; valid_i = v; inst_i = in;
    inst_addr_i = ad; op1_i = a; op2_i = b; reg_we_i = w; reg_waddr_i = wa;
    x.tag = tag; x.o = e; x.chk = chk; x.sc = sc; x.bc = bc; x.fc = fc;
    q.push_back(x);
  endtask

  // Monitor: every edge the stage presents a slot; compare it against the oldest expectation.
  initial begin
    exp_t e;
    out_t act;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = mk(valid_o, inst_o, inst_addr_o, op1_o, op2_o, reg_we_o, reg_waddr_o,
                 inst_is_load_o, rd_o);
        n_tests++;
        if (act !== e.o) begin
          n_fail++;
          $display("FAIL %s: got v=%b inst=%h addr=%h op1=%h op2=%h we=%b wa=%0d ld=%b rd=%0d, expected v=%b inst=%h addr=%h op1=%h op2=%h we=%b wa=%0d ld=%b rd=%0d",
                   e.tag, act.valid, act.inst, act.addr, act.op1, act.op2, act.we, act.wa,
                   act.ld, act.rd, e.o.valid, e.o.inst, e.o.addr, e.o.op1, e.o.op2, e.o.we,
                   e.o.wa, e.o.ld, e.o.rd);
        end
`ifdef PIPE_PERF_CNT_EN
        if (e.chk) begin
          n_tests++;
          if ({stall_cnt_o, bubble_cnt_o, flush_cnt_o} !== {e.sc, e.bc, e.fc}) begin
            n_fail++;
            $display("FAIL %s counters: got stall=%h bubble=%h flush=%h, expected stall=%h bubble=%h flush=%h",
                     e.tag, stall_cnt_o, bubble_cnt_o, flush_cnt_o, e.sc, e.bc, e.fc);
          end
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    out_t L2, LA, L5, LB;
    R  = mk(1'b0, 32'h0000_0013, '0, '0, '0, 1'b0, 5'd0, 1'b0, 5'd0);
    L2 = mk(1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7, 1'b1, 5'd1, 1'b1, 5'd1);
    LA = mk(1'b1, 32'h0031_01B3, 32'h104, 32'd11, 32'd22, 1'b1, 5'd3, 1'b0, 5'd3);
    L5 = mk(1'b1, 32'h0001_2283, 32'h108, 32'hDEAD_BEEF, 32'd1, 1'b1, 5'd5, 1'b1, 5'd5);
    LB = mk(1'b1, 32'h0031_01B3, 32'h10C, 32'd3, 32'd4, 1'b0, 5'd3, 1'b0, 5'd3);

    for (int i = 0; i < 2; i++)
      drive("reset", 1'b1, 6'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
            $urandom, $urandom, 1'($urandom), 5'($urandom), R, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("load_lw", 1'b0, 6'b000000, 1'b0, 1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, L2, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++)
      drive("hold", 1'b0, 6'b001100, 1'(i == 2), 1'b1, 32'h0031_0233 + 32'(i), 32'h200 + 32'(i),
            32'd9, 32'd9, 1'b0, 5'd4, L2, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("bubble", 1'b0, 6'b000100, 1'b0, 1'b1, 32'h0031_01B3, 32'h104, 32'd11, 32'd22,
          1'b1, 5'd3, R, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("load_add", 1'b0, 6'b000000, 1'b0, 1'b1, 32'h0031_01B3, 32'h104, 32'd11, 32'd22,
          1'b1, 5'd3, LA, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("flush", 1'b0, 6'b000000, 1'b1, 1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, R, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("invalid_in", 1'b0, 6'b000000, 1'b0, 1'b0, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, R, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("load_lw_x5", 1'b0, 6'b110011, 1'b0, 1'b1, 32'h0001_2283, 32'h108, 32'hDEAD_BEEF,
          32'd1, 1'b1, 5'd5, L5, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("illegal_hold", 1'b0, 6'b001000, 1'b1, 1'b1, 32'h0031_01B3, 32'h300, 32'd1, 32'd2,
          1'b0, 5'd9, L5, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("reset_mid_stall", 1'b1, 6'b001100, 1'b1, 1'b1, 32'h0031_01B3, 32'h300, 32'd1,
          32'd2, 1'b1, 5'd9, R, 1'b0, 4'd0, 4'd0, 4'd0);
    drive("load_after_rst", 1'b0, 6'b000000, 1'b0, 1'b1, 32'h0031_01B3, 32'h10C, 32'd3,
          32'd4, 1'b0, 5'd3, LB, 1'b0, 4'd0, 4'd0, 4'd0);

`ifdef PIPE_PERF_CNT_EN
    drive("cnt_reset", 1'b1, 6'b000000, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 5'd0, R,
          1'b1, 4'd0, 4'd0, 4'd0);
    for (int i = 1; i <= 20; i++)
      drive("cnt_hold", 1'b0, 6'b001100, 1'b0, 1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
            1'b1, 5'd1, R, 1'b1, (i > 15) ? 4'hF : 4'(i), 4'd0, 4'd0);
    drive("cnt_bubble", 1'b0, 6'b000100, 1'b0, 1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, R, 1'b1, 4'hF, 4'd1, 4'd0);
    drive("cnt_flush_v", 1'b0, 6'b000000, 1'b1, 1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, R, 1'b1, 4'hF, 4'd1, 4'd1);
    drive("cnt_flush_nv", 1'b0, 6'b000000, 1'b1, 1'b0, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, R, 1'b1, 4'hF, 4'd1, 4'd1);
    drive("cnt_clear", 1'b1, 6'b001100, 1'b1, 1'b1, 32'h00A1_2083, 32'h100, 32'd5, 32'd7,
          1'b1, 5'd1, R, 1'b1, 4'd0, 4'd0, 4'd0);
`endif

    repeat (2) @(posedge clk_i);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
